// File: rtl/axi_req_arbiter_pkg.sv
// Shared types and constants for the AXI request arbiter.
package axi_req_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_W,
    S_B
  } state_t;

  localparam logic       ID_INST    = 1'b0;
  localparam logic       ID_DATA    = 1'b1;
  localparam logic [2:0] AXI_SIZE_4 = 3'd2;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef struct packed {
    logic [3:0]  len;
    logic [31:0] addr;
  } ird_req_t;

  typedef struct packed {
    logic [3:0]  strb;
    logic [31:0] data;
    logic [31:0] addr;
  } wr_req_t;

endpackage

// File: rtl/axi_req_latch.sv
// Pending-request latch: holds one request (valid + payload) until granted.
module axi_req_latch #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         set_i,
  input  logic         clr_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // A new request is accepted when empty, or when the held one is being
  // granted this same cycle; otherwise a pulse on a full latch is dropped.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (set_i && (!valid_q || clr_i)) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (clr_i) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/axi_req_arbiter.sv
// Arbitrates instruction-read, data-read and write requests onto a single
// AXI master port, one transaction outstanding at a time.
module axi_req_arbiter
  import axi_req_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  // requester side
  input  logic        axir_ireq,
  input  logic [31:0] axir_iaddr,
  input  logic [3:0]  axir_ilen,
  input  logic        axir_dreq,
  input  logic [31:0] axir_daddr,
  output logic        axir_rdy,
  output logic [31:0] axir_data,
  output logic        axir_rid,
  output logic        axir_last,
  input  logic        axiw_req,
  input  logic [31:0] axiw_addr,
  input  logic [31:0] axiw_data,
  input  logic [31:0] axiw_sel,
  output logic        axiw_rdy,
  // AXI read address
  output logic        arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [31:0] rdata,
  input  logic [0:0]  rid,
  input  logic        rvalid,
  input  logic        rlast,
  output logic        rready,
  // AXI write address / data / response
  output logic        awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  state_t      state_q;
  logic        arid_q, arvalid_q, awvalid_q, wvalid_q;
  logic [31:0] araddr_q, awaddr_q, wdata_q;
  logic [3:0]  arlen_q, wstrb_q;

  ird_req_t    i_pl;
  wr_req_t     w_pl;
  logic [31:0] d_addr;
  logic        i_vld, d_vld, w_vld;
  logic        i_clr, d_clr, w_clr;

  // Grant decode: write beats data read beats instruction read.
  always_comb begin
    w_clr = (state_q == S_IDLE) && w_vld;
    d_clr = (state_q == S_IDLE) && !w_vld && d_vld;
    i_clr = (state_q == S_IDLE) && !w_vld && !d_vld && i_vld;
  end

  axi_req_latch #(.W($bits(ird_req_t))) u_ilatch (
    .clk     (clk),
    .rst     (rst),
    .set_i   (axir_ireq),
    .clr_i   (i_clr),
    .data_i  ({axir_ilen, axir_iaddr}),
    .valid_o (i_vld),
    .data_o  (i_pl)
  );

  axi_req_latch #(.W(32)) u_dlatch (
    .clk     (clk),
    .rst     (rst),
    .set_i   (axir_dreq),
    .clr_i   (d_clr),
    .data_i  (axir_daddr),
    .valid_o (d_vld),
    .data_o  (d_addr)
  );

  axi_req_latch #(.W($bits(wr_req_t))) u_wlatch (
    .clk     (clk),
    .rst     (rst),
    .set_i   (axiw_req),
    .clr_i   (w_clr),
    .data_i  ({axiw_sel[3:0], axiw_data, axiw_addr}),
    .valid_o (w_vld),
    .data_o  (w_pl)
  );

  // Transaction FSM with registered AR/AW/W channel outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      arid_q    <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arvalid_q <= 1'b0;
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wvalid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_vld) begin
            awaddr_q  <= w_pl.addr;
            wdata_q   <= w_pl.data;
            wstrb_q   <= w_pl.strb;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= S_W;
          end else if (d_vld) begin
            arid_q    <= ID_DATA;
            araddr_q  <= d_addr;
            arlen_q   <= '0;
            arvalid_q <= 1'b1;
            state_q   <= S_AR;
          end else if (i_vld) begin
            arid_q    <= ID_INST;
            araddr_q  <= i_pl.addr;
            arlen_q   <= i_pl.len;
            arvalid_q <= 1'b1;
            state_q   <= S_AR;
          end
        end
        S_AR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            state_q   <= S_R;
          end
        end
        S_R: begin
          if (rvalid && rlast) state_q <= S_IDLE;
        end
        S_W: begin
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          // A channel counts as done if it already dropped or handshakes now.
          if ((!awvalid_q || awready) && (!wvalid_q || wready)) state_q <= S_B;
        end
        S_B: begin
          if (bvalid) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arsize  = AXI_SIZE_4;
  assign arburst = BURST_INCR;
  assign arvalid = arvalid_q;
  assign rready  = (state_q == S_R);

  assign awid    = 1'b0;
  assign awaddr  = awaddr_q;
  assign awlen   = '0;
  assign awsize  = AXI_SIZE_4;
  assign awburst = BURST_INCR;
  assign awvalid = awvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = (state_q == S_B);

  assign axir_rdy  = rvalid && rready;
  assign axir_data = rdata;
  assign axir_rid  = rid[0];
  assign axir_last = rlast;
  assign axiw_rdy  = bvalid && bready;

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Directed bench for axi_req_arbiter: the main process drives requests and
// the AXI slave side, a negedge monitor scores AR/AW/W handshakes.
module tb_axi_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        axir_ireq, axir_dreq, axiw_req;
  logic [31:0] axir_iaddr, axir_daddr, axiw_addr, axiw_data, axiw_sel;
  logic [3:0]  axir_ilen;
  logic        axir_rdy, axir_rid, axir_last, axiw_rdy;
  logic [31:0] axir_data;
  logic        arid, arvalid, arready, rvalid, rlast, rready;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [3:0]  arlen, awlen, wstrb;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic [0:0]  rid;
  logic        awid, awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  always #5 clk = ~clk;

  axi_req_arbiter dut (
    .clk(clk), .rst(rst),
    .axir_ireq(axir_ireq), .axir_iaddr(axir_iaddr), .axir_ilen(axir_ilen),
    .axir_dreq(axir_dreq), .axir_daddr(axir_daddr), .axir_rdy(axir_rdy),
    .axir_data(axir_data), .axir_rid(axir_rid), .axir_last(axir_last),
    .axiw_req(axiw_req), .axiw_addr(axiw_addr), .axiw_data(axiw_data),
    .axiw_sel(axiw_sel), .axiw_rdy(axiw_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rid(rid), .rvalid(rvalid), .rlast(rlast), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bvalid(bvalid), .bready(bready)
  );

  // Expected handshakes: AR = {arid, araddr, arlen}, AW = awaddr, W = {wdata, wstrb}
  logic [36:0] ar_q[$];
  logic [31:0] aw_q[$];
  logic [35:0] w_q[$];

  int tests = 0, errors = 0;
  int mon_tests = 0, mon_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: inputs settle at posedge+1, so negedge sees the
  // values that the next rising edge will handshake on.
  always @(negedge clk) begin
    if (!rst) begin
      if (arvalid && arready) begin
        mon_tests++;
        if (ar_q.size() == 0) begin
          mon_errors++;
          $display("FAIL ar_unexpected: got 0x%0h expected none", {arid, araddr, arlen});
        end else begin
          logic [36:0] e;
          e = ar_q.pop_front();
          if ({arid, araddr, arlen} !== e) begin
            mon_errors++;
            $display("FAIL ar_hs: got 0x%0h expected 0x%0h", {arid, araddr, arlen}, e);
          end
        end
      end
      if (awvalid && awready) begin
        mon_tests++;
        if (aw_q.size() == 0) begin
          mon_errors++;
          $display("FAIL aw_unexpected: got 0x%0h expected none", awaddr);
        end else begin
          logic [31:0] e;
          e = aw_q.pop_front();
          if (awaddr !== e) begin
            mon_errors++;
            $display("FAIL aw_hs: got 0x%0h expected 0x%0h", awaddr, e);
          end
        end
      end
      if (wvalid && wready) begin
        mon_tests++;
        if (w_q.size() == 0) begin
          mon_errors++;
          $display("FAIL w_unexpected: got 0x%0h expected none", {wdata, wstrb});
        end else begin
          logic [35:0] e;
          e = w_q.pop_front();
          if ({wdata, wstrb} !== e) begin
            mon_errors++;
            $display("FAIL w_hs: got 0x%0h expected 0x%0h", {wdata, wstrb}, e);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    axir_ireq = 0; axir_dreq = 0; axiw_req = 0;
    axir_iaddr = '0; axir_ilen = '0; axir_daddr = '0;
    axiw_addr = '0; axiw_data = '0; axiw_sel = '0;
    arready = 0; rvalid = 0; rlast = 0; rdata = '0; rid = '0;
    awready = 0; wready = 0; bvalid = 0;
    tick(); tick();
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_bready", bready, 0);
    rst = 1'b0;
    tick();

    // ---- inst burst of 4 ----
    axir_ireq = 1; axir_iaddr = 32'hBFC0_0000; axir_ilen = 4'd3;
    ar_q.push_back({1'b0, 32'hBFC0_0000, 4'd3});
    tick(); axir_ireq = 0;
    check("t1_arvalid_n1", arvalid, 0);
    tick();
    check("t1_arvalid_n2", arvalid, 1);
    check("t1_arid", arid, 0);
    check("t1_arlen", arlen, 3);
    arready = 1; tick(); arready = 0;
    check("t1_arvalid_drop", arvalid, 0);
    check("t1_rready", rready, 1);
    for (int i = 0; i < 4; i++) begin
      rvalid = 1; rlast = (i == 3); rdata = 32'h100 + i;
      #1;
      check("t1_axir_rdy", axir_rdy, 1);
      check("t1_axir_data", axir_data, 32'h100 + i);
      tick();
    end
    rvalid = 0; rlast = 0; #1;
    check("t1_idle_rready", rready, 0);

    // ---- simultaneous write + data read: write first ----
    axiw_req = 1; axiw_addr = 32'h8000_1000; axiw_data = 32'hDEAD_BEEF; axiw_sel = 32'hF;
    axir_dreq = 1; axir_daddr = 32'h8000_1000;
    aw_q.push_back(32'h8000_1000);
    w_q.push_back({32'hDEAD_BEEF, 4'hF});
    ar_q.push_back({1'b1, 32'h8000_1000, 4'd0});
    tick(); axiw_req = 0; axir_dreq = 0;
    tick();
    check("t2_awvalid", awvalid, 1);
    check("t2_wvalid", wvalid, 1);
    check("t2_arvalid_held", arvalid, 0);
    awready = 1; wready = 1; tick(); awready = 0; wready = 0;
    check("t2_aw_drop", awvalid, 0);
    check("t2_w_drop", wvalid, 0);
    check("t2_bready", bready, 1);
    check("t2_arvalid_in_b", arvalid, 0);
    bvalid = 1; #1;
    check("t2_axiw_rdy", axiw_rdy, 1);
    tick(); bvalid = 0; #1;
    check("t2_axiw_rdy_low", axiw_rdy, 0);
    check("t2_arvalid_idle", arvalid, 0);
    tick();
    check("t2_arvalid", arvalid, 1);
    check("t2_arid", arid, 1);
    check("t2_arlen", arlen, 0);
    arready = 1; tick(); arready = 0;
    rvalid = 1; rlast = 1; rid = 1'b1; #1;
    check("t2_axir_rid", axir_rid, 1);
    tick(); rvalid = 0; rlast = 0; rid = '0;

    // ---- AW handshakes two cycles before W ----
    axiw_req = 1; axiw_addr = 32'h0000_0040; axiw_data = 32'h1234_5678; axiw_sel = 32'hABCD_0003;
    aw_q.push_back(32'h0000_0040);
    w_q.push_back({32'h1234_5678, 4'h3});
    tick(); axiw_req = 0;
    tick();
    check("t3_wstrb", wstrb, 4'h3);
    awready = 1; tick(); awready = 0;
    check("t3_aw_drop", awvalid, 0);
    check("t3_w_hold1", wvalid, 1);
    check("t3_no_b1", bready, 0);
    tick();
    check("t3_w_hold2", wvalid, 1);
    check("t3_no_b2", bready, 0);
    wready = 1; tick(); wready = 0;
    check("t3_w_drop", wvalid, 0);
    check("t3_bready", bready, 1);
    bvalid = 1; #1;
    check("t3_axiw_rdy", axiw_rdy, 1);
    tick(); #0;
    check("t3_axiw_rdy_once", axiw_rdy, 0);
    check("t3_bready_low", bready, 0);
    tick(); bvalid = 0;

    // ---- arready held low; inst pulses during the wait ----
    axir_dreq = 1; axir_daddr = 32'h0000_2000;
    ar_q.push_back({1'b1, 32'h0000_2000, 4'd0});
    tick(); axir_dreq = 0;
    tick();
    for (int c = 0; c < 5; c++) begin
      check("t4_arvalid_stable", arvalid, 1);
      check("t4_araddr_stable", araddr, 32'h0000_2000);
      if (c == 1) begin
        axir_ireq = 1; axir_iaddr = 32'h1111_0000; axir_ilen = 4'd7;
        ar_q.push_back({1'b0, 32'h1111_0000, 4'd7});
      end
      if (c == 3) begin
        axir_ireq = 1; axir_iaddr = 32'h2222_0000; axir_ilen = 4'd1;
      end
      tick(); axir_ireq = 0;
    end
    arready = 1; tick(); arready = 0;
    rvalid = 1; rlast = 1; tick(); rvalid = 0; rlast = 0;
    tick();
    check("t4_inst_arvalid", arvalid, 1);
    check("t4_inst_araddr", araddr, 32'h1111_0000);
    check("t4_inst_arlen", arlen, 7);
    arready = 1; tick(); arready = 0;
    rvalid = 1; rlast = 1; tick(); rvalid = 0; rlast = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t4_second_ignored", arvalid, 0);
    end

    // ---- reset mid-burst ----
    axir_ireq = 1; axir_iaddr = 32'h0000_3000; axir_ilen = 4'd3;
    ar_q.push_back({1'b0, 32'h0000_3000, 4'd3});
    tick(); axir_ireq = 0;
    tick();
    arready = 1; tick(); arready = 0;
    rvalid = 1; rdata = 32'h55; tick();
    axir_dreq = 1; axir_daddr = 32'h0000_5000; tick(); axir_dreq = 0;
    rst = 1; rvalid = 0;
    tick();
    check("t5_rst_rready", rready, 0);
    check("t5_rst_arvalid", arvalid, 0);
    check("t5_rst_araddr", araddr, 0);
    check("t5_rst_arlen", arlen, 0);
    check("t5_rst_awvalid", awvalid, 0);
    check("t5_rst_wvalid", wvalid, 0);
    check("t5_rst_wdata", wdata, 0);
    check("t5_rst_bready", bready, 0);
    check("t5_rst_axir_rdy", axir_rdy, 0);
    rst = 0;
    tick(); tick();
    check("t5_latch_empty", arvalid, 0);
    axir_dreq = 1; axir_daddr = 32'h0000_4000;
    ar_q.push_back({1'b1, 32'h0000_4000, 4'd0});
    tick(); axir_dreq = 0;
    check("t5_fresh_n1", arvalid, 0);
    tick();
    check("t5_fresh_n2", arvalid, 1);
    check("t5_fresh_araddr", araddr, 32'h0000_4000);
    arready = 1; tick(); arready = 0;
    rvalid = 1; rlast = 1; tick(); rvalid = 0; rlast = 0;
    tick(); tick();

    check("end_ar_q_empty", ar_q.size(), 0);
    check("end_aw_q_empty", aw_q.size(), 0);
    check("end_w_q_empty", w_q.size(), 0);

    tests  += mon_tests;
    errors += mon_errors;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/axi_req_arbiter.md
AXI_REQ_ARBITER -- requirements
Module: axi_req_arbiter

Interface
REQ-001 Parameters: none; all AXI field widths are fixed.
REQ-002 clk  in  1  single clock, all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 axir_ireq  in  1  inst-read request pulse, one cycle.
REQ-005 axir_iaddr  in  32  inst-read address, valid with axir_ireq.
REQ-006 axir_ilen  in  4  inst-read burst length-1, valid with axir_ireq.
REQ-007 axir_dreq  in  1  data-read request pulse, one cycle.
REQ-008 axir_daddr  in  32  data-read address, valid with axir_dreq.
REQ-009 axir_rdy  out  1  read beat valid to requesters (rvalid && rready).
REQ-010 axiw_req  in  1  write request pulse, one cycle.
REQ-011 axiw_addr  in  32  write address, valid with axiw_req.
REQ-012 axiw_data  in  32  write data, valid with axiw_req.
REQ-013 axiw_sel  in  32  byte enables; bits [3:0] used, [31:4] ignored.
REQ-014 axiw_rdy  out  1  write-complete pulse, one cycle.
REQ-015 arid  out  1  0 = instruction, 1 = data.
REQ-016 araddr  out  32  read address.
REQ-017 arlen  out  4  burst length-1.
REQ-018 arvalid  out  1  AR valid.
REQ-019 arready  in  1  AR ready.
REQ-020 rvalid  in  1  R valid.
REQ-021 rlast  in  1  last beat of burst.
REQ-022 rready  out  1  R ready.
REQ-023 awaddr  out  32  write address.
REQ-024 awvalid  out  1  AW valid.
REQ-025 awready  in  1  AW ready.
REQ-026 wdata  out  32  write data.
REQ-027 wstrb  out  4  write strobes = axiw_sel[3:0].
REQ-028 wvalid  out  1  W valid.
REQ-029 wready  in  1  W ready.
REQ-030 bvalid  in  1  B valid.
REQ-031 bready  out  1  B ready.

Function
REQ-032 Top level wires rdata->axir_data, rid[0]->axir_rid, rlast->axir_last directly; ties arsize/awsize=2, arburst/awburst=INCR, awlen=0, wlast=1, awid=0.
REQ-033 Each requester has a pending latch (valid + payload) set on its request pulse; pulse while its latch is already set is ignored; set and clear in the same cycle leaves the latch set with the new payload.
REQ-034 FSM states S_IDLE, S_AR, S_R, S_W, S_B; one AXI transaction outstanding at a time.
REQ-035 S_IDLE priority: write > data read > inst read; the grant loads AR or AW/W output registers and clears that latch; -> S_W on write, else -> S_AR.
REQ-036 Latency: pulse at cycle N with FSM idle -> arvalid/awvalid high from cycle N+2.
REQ-037 S_AR: arvalid held with stable arid/araddr/arlen until arready; -> S_R on handshake; data read drives arlen=0, inst read drives arlen=axir_ilen.
REQ-038 S_R: rready=1; axir_rdy=rvalid (combinational); rvalid && rlast -> S_IDLE.
REQ-039 S_W: awvalid and wvalid assert together, each drops independently after its handshake; both done (same or different cycles) -> S_B.
REQ-040 S_B: bready=1; axiw_rdy=bvalid (combinational, one cycle); bvalid -> S_IDLE; bresp ignored.
REQ-041 No flush input; issued transactions always run to completion; the requester discards unwanted responses.

Reset
REQ-042 On rst: FSM in S_IDLE, all latches cleared, all outputs 0; mid-transaction reset aborts silently; the AXI slave is reset in the same cycle.

Structure
REQ-043 Shared package holds FSM state encoding and constants ID_INST=0, ID_DATA=1; sub-module axi_req_latch (valid + payload) is instantiated three times.

Verification
REQ-044 Inst pulse, addr 0xBFC00000, ilen 3 -> arvalid at N+2, arid 0, arlen 3; four rvalid beats -> four axir_rdy; rlast -> S_IDLE.
REQ-045 Write 0x80001000, data 0xDEADBEEF, sel 0xF and data read 0x80001000 in the same cycle -> AW/W issued first, then AR arid 1 after bvalid.
REQ-046 awready 2 cycles before wready -> awvalid drops early, wvalid holds; S_B only after both; axiw_rdy is exactly one cycle.
REQ-047 arready held low 5 cycles -> arvalid and araddr stable throughout; second inst pulse during wait ignored.
REQ-048 rst asserted in S_R mid-burst -> next cycle all outputs 0, latches empty; fresh dreq issues normally.
